// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared CPU-bus types and register addresses for the NES system slice.
package nes_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DMA_LEN = 256;

  localparam logic [ADDR_W-1:0] DMA_REG_ADDR = 16'h4014;
  localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    GET,
    PUT,
    DGET
  } dma_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              re;
    logic [DATA_W-1:0] wr_data;
  } bus_req_t;

endpackage

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: owns the CPU memory bus and runs sprite OAM DMA on a $4014 write.
// Defining DMC_DMA_EN adds a DMC sample-fetch channel that takes priority over OAM.
module oam_dma_arbiter
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = nes_bus_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = nes_bus_pkg::OAMDATA_ADDR,
  parameter int unsigned DMA_LEN      = nes_bus_pkg::DMA_LEN
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_clk_en,
  input  logic              cpu_cyc_par,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic [DATA_W-1:0] cpu_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
`ifdef DMC_DMA_EN
  input  logic              dmc_req,
  input  logic [ADDR_W-1:0] dmc_addr,
  output logic              dmc_ack,
  output logic [DATA_W-1:0] dmc_data,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              cpu_sus,
  output logic              dma_busy
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t        state_q;
  dma_state_t        state_d;
  logic [7:0]        page_q;
  logic [7:0]        idx_q;
  logic [DATA_W-1:0] latch_q;
  logic              trigger_c;
  logic              last_c;
  bus_req_t          core_req;
  bus_req_t          dma_req;
  bus_req_t          bus_c;

  assign trigger_c = (state_q == IDLE) && !cpu_re && (cpu_addr == DMA_REG_ADDR);
  assign last_c    = (idx_q == LAST_IDX);

`ifdef DMC_DMA_EN
  logic       dmc_pend_q;
  logic       oam_act_q;
  dma_state_t slot_c;

  // A pending DMC fetch steals the next get slot
  assign slot_c = dmc_pend_q ? DGET : GET;

  // DMC request latch and OAM-transfer-in-progress flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dmc_pend_q <= 1'b0;
      oam_act_q  <= 1'b0;
    end else if (cpu_clk_en) begin
      if (state_q == DGET)   dmc_pend_q <= 1'b0;
      else if (dmc_req)      dmc_pend_q <= 1'b1;
      if (trigger_c)                     oam_act_q <= 1'b1;
      else if (state_q == PUT && last_c) oam_act_q <= 1'b0;
    end
  end

  assign dmc_ack  = cpu_clk_en && (state_q == DGET);
  assign dmc_data = mem_rd_data;
  assign dma_busy = oam_act_q || trigger_c;
`else
  assign dma_busy = (state_q != IDLE) || trigger_c;
`endif

  assign cpu_sus = (state_q != IDLE);

  // State, page, index and data latch advance once per CPU cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      page_q  <= 8'd0;
      idx_q   <= 8'd0;
      latch_q <= '0;
    end else if (cpu_clk_en) begin
      state_q <= state_d;
      if (trigger_c)        page_q  <= cpu_wr_data;
      if (state_q == GET)   latch_q <= mem_rd_data;
      if (state_q == PUT)   idx_q   <= last_c ? 8'd0 : idx_q + 8'd1;
    end
  end

  // Next-state: halt, align gets to even cycles, then alternate get/put
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef DMC_DMA_EN
      IDLE:  if (trigger_c || dmc_req || dmc_pend_q) state_d = HALT;
      HALT:  state_d = (oam_act_q && cpu_cyc_par) ? slot_c : ALIGN;
      ALIGN: state_d = cpu_cyc_par ? slot_c : ALIGN;
      PUT:   state_d = last_c ? IDLE : slot_c;
      DGET:  state_d = oam_act_q ? ALIGN : IDLE;
`else
      IDLE:  if (trigger_c) state_d = HALT;
      HALT:  state_d = cpu_cyc_par ? GET : ALIGN;
      ALIGN: state_d = GET;
      PUT:   state_d = last_c ? IDLE : GET;
`endif
      GET:     state_d = PUT;
      default: state_d = IDLE;
    endcase
  end

  // Bus mux: core passes through when idle, otherwise the DMA request drives memory
  always_comb begin
    core_req.addr    = cpu_addr;
    core_req.re      = cpu_re;
    core_req.wr_data = cpu_wr_data;
    dma_req.addr     = cpu_addr;
    dma_req.re       = 1'b1;
    dma_req.wr_data  = cpu_wr_data;
    case (state_q)
      GET: dma_req.addr = {page_q, idx_q};
      PUT: begin
        dma_req.addr    = OAMDATA_ADDR;
        dma_req.re      = 1'b0;
        dma_req.wr_data = latch_q;
      end
`ifdef DMC_DMA_EN
      DGET: dma_req.addr = dmc_addr;
`endif
      default: ;
    endcase
    bus_c = (state_q == IDLE) ? core_req : dma_req;
  end

  assign mem_addr    = bus_c.addr;
  assign mem_re      = bus_c.re;
  assign mem_wr_data = bus_c.wr_data;

endmodule
